// File: rtl/rank_class_sorter.sv
// Per-channel sequential bitonic sorter with rank-based three-way block classification.
// One compare-exchange layer per cycle; all channels share the layer schedule.
module rank_class_sorter #(
  parameter int unsigned N_BLK = 16,
  parameter int unsigned N_CH  = 3,
  parameter int unsigned DW    = 8,
  localparam int unsigned IDXW = $clog2(N_BLK)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  output logic                          o_ready,
  input  logic [N_BLK*N_CH*DW-1:0]      i_data,
  input  logic [N_CH*(IDXW+1)-1:0]      i_thr_lo,
  input  logic [N_CH*(IDXW+1)-1:0]      i_thr_hi,
  output logic [N_CH*N_BLK*IDXW-1:0]    o_order,
  output logic [N_CH*N_BLK*2-1:0]       o_class,
  output logic                          o_done
);

  localparam int unsigned TW    = IDXW + 1;
  localparam int unsigned NPAIR = N_BLK / 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SORT  = 2'd1;
  localparam logic [1:0] ST_CLASS = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  // lvl holds merge level k-1, sub holds sub-step j-1
  logic [IDXW-1:0] lvl_q, lvl_d, sub_q, sub_d;

  logic [N_CH-1:0][N_BLK-1:0][DW-1:0]   data_q, data_d;
  logic [N_CH-1:0][N_BLK-1:0][IDXW-1:0] idx_q, idx_d;
  logic [N_CH-1:0][N_BLK-1:0][1:0]      class_q, class_d;
  logic [N_CH-1:0][TW-1:0]              thr_lo_q, thr_lo_d, thr_hi_q, thr_hi_d;

  logic [NPAIR-1:0][IDXW-1:0] pair_lo, pair_hi;

  // Position pairs for the current layer, identical across channels.
  always_comb begin
    int   s, base, off, lo_pos, hi_pos;
    logic mirror;
    s      = 1;
    base   = 0;
    off    = 0;
    lo_pos = 0;
    hi_pos = 0;
    mirror = (sub_q == lvl_q);
    s      = mirror ? int'(lvl_q) + 1 : int'(sub_q) + 1;
    for (int m = 0; m < int'(NPAIR); m++) begin
      base       = (m >> (s - 1)) << s;
      off        = m & ((1 << (s - 1)) - 1);
      lo_pos     = base + off;
      hi_pos     = mirror ? base + (1 << s) - 1 - off : lo_pos + (1 << (s - 1));
      pair_lo[m] = lo_pos[IDXW-1:0];
      pair_hi[m] = hi_pos[IDXW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    sub_d    = sub_q;
    data_d   = data_q;
    idx_d    = idx_q;
    class_d  = class_q;
    thr_lo_d = thr_lo_q;
    thr_hi_d = thr_hi_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          for (int c = 0; c < int'(N_CH); c++) begin
            for (int b = 0; b < int'(N_BLK); b++) begin
              data_d[c][b] = i_data[(b*N_CH+c)*DW +: DW];
              idx_d[c][b]  = IDXW'(b);
            end
          end
          thr_lo_d = i_thr_lo;
          thr_hi_d = i_thr_hi;
          lvl_d    = '0;
          sub_d    = '0;
          state_d  = ST_SORT;
        end
      end
      ST_SORT: begin
        // Key is {sample, index}, so ties resolve by ascending original index.
        for (int c = 0; c < int'(N_CH); c++) begin
          for (int m = 0; m < int'(NPAIR); m++) begin
            if ({data_q[c][pair_lo[m]], idx_q[c][pair_lo[m]]} >
                {data_q[c][pair_hi[m]], idx_q[c][pair_hi[m]]}) begin
              data_d[c][pair_lo[m]] = data_q[c][pair_hi[m]];
              idx_d[c][pair_lo[m]]  = idx_q[c][pair_hi[m]];
              data_d[c][pair_hi[m]] = data_q[c][pair_lo[m]];
              idx_d[c][pair_hi[m]]  = idx_q[c][pair_lo[m]];
            end
          end
        end
        if (sub_q == '0) begin
          if (lvl_q == IDXW'(IDXW - 1)) begin
            state_d = ST_CLASS;
          end else begin
            lvl_d = lvl_q + 1'b1;
            sub_d = lvl_q + 1'b1;
          end
        end else begin
          sub_d = sub_q - 1'b1;
        end
      end
      ST_CLASS: begin
        for (int c = 0; c < int'(N_CH); c++) begin
          for (int r = 0; r < int'(N_BLK); r++) begin
            if (TW'(r) < thr_lo_q[c]) begin
              class_d[c][idx_q[c][r]] = 2'd0;
            end else if (TW'(r) < thr_hi_q[c]) begin
              class_d[c][idx_q[c][r]] = 2'd1;
            end else begin
              class_d[c][idx_q[c][r]] = 2'd2;
            end
          end
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      lvl_q    <= '0;
      sub_q    <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      class_q  <= '0;
      thr_lo_q <= '0;
      thr_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      sub_q    <= sub_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      class_q  <= class_d;
      thr_lo_q <= thr_lo_d;
      thr_hi_q <= thr_hi_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_done  = (state_q == ST_DONE);
  assign o_order = idx_q;
  assign o_class = class_q;

endmodule

// File: tb/tb_rank_class_sorter.sv
// Scoreboard bench for rank_class_sorter: driver queues expectations, monitor checks on o_done.
module tb_rank_class_sorter;

  localparam int NB   = 16;
  localparam int NC   = 3;
  localparam int DW   = 8;
  localparam int IW   = 4;
  localparam int TW   = 5;
  localparam int DATW = NB * NC * DW;
  localparam int THW  = NC * TW;
  localparam int OW   = NC * NB * IW;
  localparam int CW   = NC * NB * 2;
  localparam int LAT  = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            ready;
  logic [DATW-1:0] data = '0;
  logic [THW-1:0]  thr_lo = '0;
  logic [THW-1:0]  thr_hi = '0;
  logic [OW-1:0]   order;
  logic [CW-1:0]   cls;
  logic            done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [OW-1:0] exp_ord_q[$];
  logic [CW-1:0] exp_cls_q[$];
  int            exp_cyc_q[$];

  rank_class_sorter #(.N_BLK(NB), .N_CH(NC), .DW(DW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .o_ready  (ready),
    .i_data   (data),
    .i_thr_lo (thr_lo),
    .i_thr_hi (thr_hi),
    .o_order  (order),
    .o_class  (cls),
    .o_done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: rank of a block = number of blocks with a smaller {sample, index} key.
  task automatic model(input logic [DATW-1:0] d, input logic [THW-1:0] lo,
                       input logic [THW-1:0] hi, output logic [OW-1:0] ord,
                       output logic [CW-1:0] cl);
    logic [DW-1:0] s, s2;
    logic [IW-1:0] bi;
    int rank;
    ord = '0;
    cl  = '0;
    for (int c = 0; c < NC; c++) begin
      for (int b = 0; b < NB; b++) begin
        s = d[(b*NC+c)*DW +: DW];
        rank = 0;
        for (int b2 = 0; b2 < NB; b2++) begin
          s2 = d[(b2*NC+c)*DW +: DW];
          if (s2 < s || (s2 == s && b2 < b)) rank++;
        end
        bi = IW'(b);
        ord[(c*NB+rank)*IW +: IW] = bi;
        if (rank < int'(lo[c*TW +: TW]))      cl[(c*NB+b)*2 +: 2] = 2'd0;
        else if (rank < int'(hi[c*TW +: TW])) cl[(c*NB+b)*2 +: 2] = 2'd1;
        else                                  cl[(c*NB+b)*2 +: 2] = 2'd2;
      end
    end
  endtask

  task automatic issue(input logic [DATW-1:0] d, input logic [THW-1:0] lo,
                       input logic [THW-1:0] hi, input logic [OW-1:0] ord,
                       input logic [CW-1:0] cl);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 256'(ready), 256'(1));
      return;
    end
    data   = d;
    thr_lo = lo;
    thr_hi = hi;
    exp_ord_q.push_back(ord);
    exp_cls_q.push_back(cl);
    exp_cyc_q.push_back(cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [DATW-1:0] d, input logic [THW-1:0] lo,
                             input logic [THW-1:0] hi);
    logic [OW-1:0] ord;
    logic [CW-1:0] cl;
    model(d, lo, hi, ord, cl);
    issue(d, lo, hi, ord, cl);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_ord_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 256'(exp_ord_q.size()), 256'(0));
  endtask

  function automatic logic [THW-1:0] thr_all(input int v);
    logic [THW-1:0] t;
    for (int c = 0; c < NC; c++) t[c*TW +: TW] = TW'(v);
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_ord_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got o_done=1 expected no pending result");
      end else begin
        check("order", 256'(order), 256'(exp_ord_q.pop_front()));
        check("class", 256'(cls), 256'(exp_cls_q.pop_front()));
        check("latency", 256'(cyc - exp_cyc_q.pop_front()), 256'(LAT));
        check("ready_low_in_done", 256'(ready), 256'(0));
      end
    end
  end

  initial begin
    logic [DATW-1:0] d, d2;
    logic [OW-1:0]   eo, keep_o;
    logic [CW-1:0]   ec, keep_c;
    logic [THW-1:0]  lo, hi;
    int n;

    #1;
    check("rst_ready", 256'(ready), 256'(1));
    check("rst_done", 256'(done), 256'(0));
    check("rst_order", 256'(order), 256'(0));
    check("rst_class", 256'(cls), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending: hand-built identity order, classes 0/1/2 at 6/10.
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++) d[(b*NC+c)*DW +: DW] = DW'(16 * b);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NB; r++) begin
        eo[(c*NB+r)*IW +: IW] = IW'(r);
        ec[(c*NB+r)*2 +: 2]   = (r < 6) ? 2'd0 : (r < 10) ? 2'd1 : 2'd2;
      end
    issue(d, thr_all(6), thr_all(10), eo, ec);

    // All equal: index tie-break gives identity, same classes.
    d = {(NB*NC){8'h80}};
    issue(d, thr_all(6), thr_all(10), eo, ec);

    // Descending: reversed order, blocks 15..10 class 0.
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++) d[(b*NC+c)*DW +: DW] = DW'(255 - b);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NB; r++) begin
        eo[(c*NB+r)*IW +: IW]        = IW'(15 - r);
        ec[(c*NB+(15-r))*2 +: 2]     = (r < 6) ? 2'd0 : (r < 10) ? 2'd1 : 2'd2;
      end
    issue(d, thr_all(6), thr_all(10), eo, ec);
    drain();

    // Mixed channels: B permuted, G descending, R ascending.
    for (int b = 0; b < NB; b++) begin
      d[(b*NC+0)*DW +: DW] = DW'(((b * 7) % 16) * 16 + 3);
      d[(b*NC+1)*DW +: DW] = DW'(255 - 8 * b);
      d[(b*NC+2)*DW +: DW] = DW'(10 * b);
    end
    lo = {5'd6, 5'd6, 5'd8};
    hi = {5'd10, 5'd11, 5'd10};
    issue_model(d, lo, hi);

    // Degenerate thresholds.
    issue_model(d, thr_all(10), thr_all(4));
    issue_model(d, thr_all(16), thr_all(16));
    issue_model(d, thr_all(0), thr_all(31));
    drain();

    // Starts during SORT and DONE must be ignored; captured data must win.
    model(d, lo, hi, keep_o, keep_c);
    issue(d, lo, hi, keep_o, keep_c);
    for (int b = 0; b < NB * NC; b++) d2[b*DW +: DW] = DW'(b * 37);
    data = d2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 256'(done), 256'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_start_ready", 256'(ready), 256'(1));
    check("hold_order", 256'(order), 256'(keep_o));
    check("hold_class", 256'(cls), 256'(keep_c));
    check("no_pending", 256'(exp_ord_q.size()), 256'(0));

    // Reset during SORT aborts with cleared outputs.
    issue_model(d2, lo, hi);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    exp_ord_q.delete();
    exp_cls_q.delete();
    exp_cyc_q.delete();
    #1;
    check("abort_ready", 256'(ready), 256'(1));
    check("abort_order", 256'(order), 256'(0));
    check("abort_class", 256'(cls), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", 256'(ready), 256'(1));
    check("abort_idle_done", 256'(done), 256'(0));
    issue_model(d, lo, hi);
    drain();

    // Random sweep, alternating narrow ranges for ties.
    for (int v = 0; v < 200; v++) begin
      for (int i = 0; i < NB * NC; i++)
        d[i*DW +: DW] = (v % 2 == 1) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 255));
      for (int c = 0; c < NC; c++) begin
        lo[c*TW +: TW] = TW'($urandom_range(0, 18));
        hi[c*TW +: TW] = TW'($urandom_range(0, 18));
      end
      issue_model(d, lo, hi);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
